// File: rtl/decompose_makehint.sv
// decompose_makehint: ML-DSA MakeHint plus HintBitPack for the signing path.
// Streams K polynomials of 256 (r0, r1) pairs, one per cycle, and writes the
// packed hint field: hint indices at 0..OMEGA-1, zero fill, then K cumulative
// per-poly counts at OMEGA..OMEGA+K-1. invalid_o flags a hint count over OMEGA.
// Optional macro MAKEHINT_COEF_HINT_OUT_EN adds hint_o / hint_valid_o, which
// report the raw per-coefficient hint bit one cycle after each accept.

package abr_params_pkg;
  parameter int MLDSA_Q      = 8380417;
  parameter int MLDSA_GAMMA2 = 261888;
endpackage

module decompose_makehint
  import abr_params_pkg::*;
#(
  parameter  int REG_SIZE = 23,
  parameter  int OMEGA    = 75,
  parameter  int K        = 8,
  localparam int ADDR_W   = $clog2(OMEGA + K)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                zeroize,
  input  logic                start_i,
  input  logic                valid_i,
  input  logic [REG_SIZE-1:0] r0_i,
  input  logic [3:0]          r1_i,
  output logic                ready_o,
  output logic                hint_wr_en_o,
  output logic [ADDR_W-1:0]   hint_wr_addr_o,
  output logic [7:0]          hint_wr_data_o,
  output logic                busy_o,
  output logic                done_o,
`ifdef MAKEHINT_COEF_HINT_OUT_EN
  output logic                hint_o,
  output logic                hint_valid_o,
`endif
  output logic                invalid_o
);

  localparam int                  POLY_W    = (K > 1) ? $clog2(K) : 1;
  localparam logic [REG_SIZE-1:0] GAMMA2_V  = REG_SIZE'(MLDSA_GAMMA2);
  localparam logic [REG_SIZE-1:0] QMG2_V    = REG_SIZE'(MLDSA_Q - MLDSA_GAMMA2);
  localparam logic [ADDR_W-1:0]   OMEGA_A   = ADDR_W'(OMEGA);
  localparam logic [ADDR_W-1:0]   OMEGA_M1  = ADDR_W'(OMEGA - 1);
  localparam logic [POLY_W-1:0]   LAST_POLY = POLY_W'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH_IDX,
    S_FLUSH_CNT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        coef_idx_q;
  logic [POLY_W-1:0] poly_idx_q;
  logic [ADDR_W-1:0] total_cnt_q;
  logic [ADDR_W-1:0] flush_ptr_q;
  logic [POLY_W-1:0] cnt_sel_q;
  logic [7:0]        poly_cnt_q [K];

  logic              accept;
  logic              hint;
  logic              room;
  logic              last_coef;
  logic              last_accept;
  logic              invalid_d;
  logic [ADDR_W-1:0] total_d;

  // Handshake: a coefficient transfers on any rising edge where valid_i and
  // ready_o are both high. ready_o depends only on the FSM state (never on
  // valid_i); valid_i low simply stalls the stream with no state change.
  assign accept      = valid_i && (state_q == S_RUN);
  assign hint        = ((r0_i > GAMMA2_V) && (r0_i < QMG2_V)) ||
                       ((r0_i == QMG2_V) && (r1_i != 4'd0));
  assign room        = total_cnt_q < OMEGA_A;
  assign last_coef   = coef_idx_q == 8'd255;
  assign last_accept = accept && last_coef && (poly_idx_q == LAST_POLY);
  // Count and invalid flag as they will be after this cycle's accept, so the
  // final accept can steer the FSM using its own hint.
  assign total_d     = (accept && hint && room) ? total_cnt_q + ADDR_W'(1) : total_cnt_q;
  assign invalid_d   = invalid_o || (accept && hint && !room);

  // State register; zeroize acts like a synchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else if (zeroize) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        ready_o = 1'b1;
        if (last_accept) begin
          if (invalid_d)              state_d = S_DONE;
          else if (total_d < OMEGA_A) state_d = S_FLUSH_IDX;
          else                        state_d = S_FLUSH_CNT;
        end
      end
      S_FLUSH_IDX: begin
        if (flush_ptr_q == OMEGA_M1) state_d = S_FLUSH_CNT;
      end
      S_FLUSH_CNT: begin
        if (cnt_sel_q == LAST_POLY) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters, per-poly counts and the registered hint buffer write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coef_idx_q     <= '0;
      poly_idx_q     <= '0;
      total_cnt_q    <= '0;
      flush_ptr_q    <= '0;
      cnt_sel_q      <= '0;
      invalid_o      <= 1'b0;
      hint_wr_en_o   <= 1'b0;
      hint_wr_addr_o <= '0;
      hint_wr_data_o <= '0;
      for (int j = 0; j < K; j++) poly_cnt_q[j] <= '0;
`ifdef MAKEHINT_COEF_HINT_OUT_EN
      hint_o         <= 1'b0;
      hint_valid_o   <= 1'b0;
`endif
    end else if (zeroize) begin
      coef_idx_q     <= '0;
      poly_idx_q     <= '0;
      total_cnt_q    <= '0;
      flush_ptr_q    <= '0;
      cnt_sel_q      <= '0;
      invalid_o      <= 1'b0;
      hint_wr_en_o   <= 1'b0;
      hint_wr_addr_o <= '0;
      hint_wr_data_o <= '0;
      for (int j = 0; j < K; j++) poly_cnt_q[j] <= '0;
`ifdef MAKEHINT_COEF_HINT_OUT_EN
      hint_o         <= 1'b0;
      hint_valid_o   <= 1'b0;
`endif
    end else begin
      hint_wr_en_o   <= 1'b0;
      hint_wr_addr_o <= '0;
      hint_wr_data_o <= '0;
`ifdef MAKEHINT_COEF_HINT_OUT_EN
      hint_valid_o   <= accept;
      hint_o         <= accept && hint;
`endif
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            coef_idx_q  <= '0;
            poly_idx_q  <= '0;
            total_cnt_q <= '0;
            invalid_o   <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (room && hint) begin
              hint_wr_en_o   <= 1'b1;
              hint_wr_addr_o <= total_cnt_q;
              hint_wr_data_o <= coef_idx_q;
            end
            total_cnt_q <= total_d;
            invalid_o   <= invalid_d;
            coef_idx_q  <= coef_idx_q + 8'd1;
            if (last_coef) begin
              poly_idx_q             <= poly_idx_q + POLY_W'(1);
              poly_cnt_q[poly_idx_q] <= 8'(total_d);
            end
            if (last_accept) begin
              flush_ptr_q <= total_d;
              cnt_sel_q   <= '0;
            end
          end
        end
        S_FLUSH_IDX: begin
          hint_wr_en_o   <= 1'b1;
          hint_wr_addr_o <= flush_ptr_q;
          hint_wr_data_o <= 8'd0;
          flush_ptr_q    <= flush_ptr_q + ADDR_W'(1);
        end
        S_FLUSH_CNT: begin
          hint_wr_en_o   <= 1'b1;
          hint_wr_addr_o <= OMEGA_A + ADDR_W'(cnt_sel_q);
          hint_wr_data_o <= poly_cnt_q[cnt_sel_q];
          cnt_sel_q      <= cnt_sel_q + POLY_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
